// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding, phase strobe constants and VGA pixel widths.
package game_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 6;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REG,
        S_APPLY,
        S_SETTLE,
        S_DRAW_MAP,
        S_DRAW_LINK,
        S_DRAW_ENEMY
    } state_t;

    // Bit order: {init, idle, reg_action, apply_action, draw_map, draw_link, draw_enemy}
    localparam logic [6:0] PH_INIT   = 7'b1000000;
    localparam logic [6:0] PH_IDLE   = 7'b0100000;
    localparam logic [6:0] PH_REG    = 7'b0010000;
    localparam logic [6:0] PH_APPLY  = 7'b0001000;
    localparam logic [6:0] PH_MAP    = 7'b0000100;
    localparam logic [6:0] PH_LINK   = 7'b0000010;
    localparam logic [6:0] PH_ENEMY  = 7'b0000001;
    localparam logic [6:0] PH_NONE   = 7'b0000000;

    function automatic logic [6:0] phase_of(input state_t s);
        case (s)
            S_INIT:       return PH_INIT;
            S_IDLE:       return PH_IDLE;
            S_REG:        return PH_REG;
            S_APPLY:      return PH_APPLY;
            S_DRAW_MAP:   return PH_MAP;
            S_DRAW_LINK:  return PH_LINK;
            S_DRAW_ENEMY: return PH_ENEMY;
            default:      return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vga_port_mux.sv
// vga_port_mux: routes the active draw source's pixel port to the VGA port; idle-zero otherwise.
module vga_port_mux
    import game_pkg::*;
(
    input  state_t         state,
    input  logic [X_W-1:0] map_x,
    input  logic [Y_W-1:0] map_y,
    input  logic [C_W-1:0] map_c,
    input  logic           map_we,
    input  logic [X_W-1:0] link_x,
    input  logic [Y_W-1:0] link_y,
    input  logic [C_W-1:0] link_c,
    input  logic           link_we,
    input  logic [X_W-1:0] enemy_x,
    input  logic [Y_W-1:0] enemy_y,
    input  logic [C_W-1:0] enemy_c,
    input  logic           enemy_we,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_write
);

    always_comb
        {vga_x, vga_y, vga_colour, vga_write} =
            state == S_DRAW_MAP   ? {map_x, map_y, map_c, map_we} :
            state == S_DRAW_LINK  ? {link_x, link_y, link_c, link_we} :
            state == S_DRAW_ENEMY ? {enemy_x, enemy_y, enemy_c, enemy_we} : '0;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame phase/draw FSM with draw timeout and tick-overrun tracking; DRAW_ENEMY stage exists only when ENEMY_SEQ_EN is defined.
module frame_sequencer
    import game_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
)
(
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           frame_tick,
    input  logic           map_done,
    input  logic           link_done,
    input  logic           enemy_done,
    input  logic [X_W-1:0] map_x,
    input  logic [Y_W-1:0] map_y,
    input  logic [C_W-1:0] map_c,
    input  logic           map_we,
    input  logic [X_W-1:0] link_x,
    input  logic [Y_W-1:0] link_y,
    input  logic [C_W-1:0] link_c,
    input  logic           link_we,
    input  logic [X_W-1:0] enemy_x,
    input  logic [Y_W-1:0] enemy_y,
    input  logic [C_W-1:0] enemy_c,
    input  logic           enemy_we,
    output logic           init,
    output logic           idle,
    output logic           reg_action,
    output logic           apply_action,
    output logic           draw_map,
    output logic           draw_link,
    output logic           draw_enemy,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_write,
    output logic [7:0]     overrun_count,
    output logic           timeout_err
);

    state_t         state, next_state;
    logic [15:0]    timer;
    logic           pending;
    logic           expired;
    logic           timed_out;
    logic [X_W-1:0] e_x;
    logic [Y_W-1:0] e_y;
    logic [C_W-1:0] e_c;
    logic           e_we;

    assign expired = timer == TIMEOUT_CYCLES - 16'd1;

    always_comb begin
        next_state = state;
        timed_out  = 1'b0;
        {init, idle, reg_action, apply_action, draw_map, draw_link, draw_enemy} = phase_of(state);
        case (state)
            S_INIT:      next_state = start ? S_IDLE : S_INIT;
            S_IDLE:      next_state = (frame_tick || pending) ? S_REG : S_IDLE;
            S_REG:       next_state = S_APPLY;
            S_APPLY:     next_state = S_SETTLE;
            S_SETTLE:    next_state = S_DRAW_MAP;
            S_DRAW_MAP: begin
                next_state = map_done ? S_DRAW_LINK : expired ? S_IDLE : S_DRAW_MAP;
                timed_out  = expired && !map_done;
            end
`ifdef ENEMY_SEQ_EN
            S_DRAW_LINK: begin
                next_state = link_done ? S_DRAW_ENEMY : expired ? S_IDLE : S_DRAW_LINK;
                timed_out  = expired && !link_done;
            end
            S_DRAW_ENEMY: begin
                next_state = (enemy_done || expired) ? S_IDLE : S_DRAW_ENEMY;
                timed_out  = expired && !enemy_done;
            end
`else
            S_DRAW_LINK: begin
                next_state = (link_done || expired) ? S_IDLE : S_DRAW_LINK;
                timed_out  = expired && !link_done;
            end
`endif
            default:     next_state = S_IDLE;
        endcase
`ifndef ENEMY_SEQ_EN
        draw_enemy = 1'b0;
`endif
    end

    // Timer restarts on every state change, so each draw state starts counting from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_INIT;
            timer         <= '0;
            pending       <= 1'b0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state <= next_state;
            timer <= (next_state != state) ? 16'd0 : timer + 16'd1;
            if (timed_out)
                timeout_err <= 1'b1;
            if (state == S_IDLE)
                pending <= 1'b0;
            else if (frame_tick) begin
                pending <= 1'b1;
                if (pending && overrun_count != 8'd255)
                    overrun_count <= overrun_count + 8'd1;
            end
        end
    end

`ifdef ENEMY_SEQ_EN
    assign {e_x, e_y, e_c, e_we} = {enemy_x, enemy_y, enemy_c, enemy_we};
`else
    logic unused_enemy;
    assign unused_enemy = &{1'b0, enemy_done, enemy_x, enemy_y, enemy_c, enemy_we};
    assign {e_x, e_y, e_c, e_we} = '0;
`endif

    vga_port_mux u_mux (
        .state      (state),
        .map_x      (map_x),
        .map_y      (map_y),
        .map_c      (map_c),
        .map_we     (map_we),
        .link_x     (link_x),
        .link_y     (link_y),
        .link_c     (link_c),
        .link_we    (link_we),
        .enemy_x    (e_x),
        .enemy_y    (e_y),
        .enemy_c    (e_c),
        .enemy_we   (e_we),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write)
    );

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed-step bench for frame_sequencer; follows ENEMY_SEQ_EN when defined.
module tb_frame_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, frame_tick;
    logic       map_done, link_done, enemy_done;
    logic [8:0] map_x, link_x, enemy_x;
    logic [7:0] map_y, link_y, enemy_y;
    logic [5:0] map_c, link_c, enemy_c;
    logic       map_we, link_we, enemy_we;
    logic       init, idle, reg_action, apply_action;
    logic       draw_map, draw_link, draw_enemy;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [5:0] vga_colour;
    logic       vga_write;
    logic [7:0] overrun_count;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    frame_sequencer #(.TIMEOUT_CYCLES(16'd100)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
        .map_done(map_done), .link_done(link_done), .enemy_done(enemy_done),
        .map_x(map_x), .map_y(map_y), .map_c(map_c), .map_we(map_we),
        .link_x(link_x), .link_y(link_y), .link_c(link_c), .link_we(link_we),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_c(enemy_c), .enemy_we(enemy_we),
        .init(init), .idle(idle), .reg_action(reg_action), .apply_action(apply_action),
        .draw_map(draw_map), .draw_link(draw_link), .draw_enemy(draw_enemy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
        .overrun_count(overrun_count), .timeout_err(timeout_err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        map_done = 1'b0; link_done = 1'b0; enemy_done = 1'b0;
        map_x = '0; map_y = '0; map_c = '0; map_we = 1'b0;
        link_x = '0; link_y = '0; link_c = '0; link_we = 1'b0;
        enemy_x = '0; enemy_y = '0; enemy_c = '0; enemy_we = 1'b0;
        tick(3);
        chk("rst_init", init, 1);
        chk("rst_strobes", {idle, reg_action, apply_action, draw_map, draw_link, draw_enemy}, 0);
        chk("rst_vga", {vga_x, vga_y, vga_colour, vga_write}, 0);
        chk("rst_overrun", overrun_count, 0);
        chk("rst_timeout", timeout_err, 0);

        // cycle 0 with start high, cycle 1 in IDLE
        reset = 1'b0; start = 1'b1;
        chk("init_c0", init, 1);
        tick(1);
        start = 1'b0;
        chk("idle_c1", idle, 1);
        chk("init_off_c1", init, 0);
        tick(9);
        chk("idle_c10", idle, 1);

        // frame at cycle 10
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        chk("reg_c11", reg_action, 1);
        chk("idle_off_c11", idle, 0);
        tick(1);
        chk("apply_c12", apply_action, 1);
        tick(1);
        chk("settle_c13", {init, idle, reg_action, apply_action, draw_map, draw_link, draw_enemy}, 0);
        tick(1);
        chk("map_c14", draw_map, 1);
        tick(1);
        link_done = 1'b1; enemy_done = 1'b1;
        tick(1);
        link_done = 1'b0; enemy_done = 1'b0;
        chk("foreign_done_ignored_c16", {draw_map, draw_link}, 2'b10);
        tick(2);
        map_done = 1'b1;
        tick(1);
        map_done = 1'b0;
        chk("link_c19", draw_link, 1);
        chk("map_off_c19", draw_map, 0);
        tick(4);
        link_done = 1'b1;
        tick(1);
        link_done = 1'b0;
`ifdef ENEMY_SEQ_EN
        chk("enemy_c24", draw_enemy, 1);
        tick(4);
        enemy_done = 1'b1;
        tick(1);
        enemy_done = 1'b0;
`else
        chk("no_enemy_c24", draw_enemy, 0);
`endif
        chk("idle_frame_end", idle, 1);
        tick(1);
        chk("tick_consumed_idle", idle, 1);
        chk("tick_consumed_overrun", overrun_count, 0);

        // two ticks while drawing the map
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        tick(3);
        chk("map_ovr", draw_map, 1);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        chk("overrun_first_pends", overrun_count, 0);
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        chk("overrun_second", overrun_count, 1);
        map_done = 1'b1;
        tick(1);
        map_done = 1'b0;
        link_done = 1'b1;
        tick(1);
        link_done = 1'b0;
`ifdef ENEMY_SEQ_EN
        enemy_done = 1'b1;
        tick(1);
        enemy_done = 1'b0;
`endif
        chk("idle_after_overrun", idle, 1);
        tick(1);
        chk("pending_reenters_reg", reg_action, 1);
        tick(3);
        chk("map_timeout_entry", draw_map, 1);

        // map source routing, then timeout with map_done held low
        map_we = 1'b1; map_x = 9'h1A5; map_y = 8'hC3; map_c = 6'h15;
        #1;
        chk("map_vga", {vga_x, vga_y, vga_colour, vga_write}, {9'h1A5, 8'hC3, 6'h15, 1'b1});
        tick(98);
        chk("timeout_not_yet", timeout_err, 0);
        tick(1);
        chk("map_at_99", draw_map, 1);
        tick(1);
        chk("idle_at_100", idle, 1);
        chk("timeout_set", timeout_err, 1);
        chk("vga_idle_zero", {vga_x, vga_y, vga_colour, vga_write}, 0);

        // link source routing with map_we also high
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        tick(3);
        map_done = 1'b1;
        tick(1);
        map_done = 1'b0;
        chk("link_mux_state", draw_link, 1);
        link_we = 1'b1; link_x = 9'd17; link_y = 8'd96; link_c = 6'h2A;
        map_x = 9'h0FF;
        enemy_we = 1'b1; enemy_x = 9'h0F0; enemy_y = 8'h5A; enemy_c = 6'h3C;
        #1;
        chk("link_vga", {vga_x, vga_y, vga_colour, vga_write}, {9'd17, 8'd96, 6'h2A, 1'b1});
        link_done = 1'b1;
        tick(1);
        link_done = 1'b0; link_we = 1'b0;
`ifdef ENEMY_SEQ_EN
        chk("enemy_mux_state", draw_enemy, 1);
        chk("enemy_vga", {vga_x, vga_y, vga_colour, vga_write}, {9'h0F0, 8'h5A, 6'h3C, 1'b1});
        enemy_done = 1'b1;
        tick(1);
        enemy_done = 1'b0;
`else
        chk("link_to_idle_no_enemy", {idle, draw_enemy}, 2'b10);
        chk("no_enemy_vga", vga_write, 0);
`endif
        chk("idle_after_link", idle, 1);
        chk("timeout_sticky", timeout_err, 1);
        enemy_we = 1'b0;

        // reset in the middle of a draw
        frame_tick = 1'b1;
        tick(1);
        frame_tick = 1'b0;
        tick(3);
        chk("map_before_reset", {draw_map, vga_write}, 2'b11);
        reset = 1'b1;
        tick(1);
        chk("reset_mid_draw", {init, draw_map, draw_link, draw_enemy, vga_write}, 5'b10000);
        chk("reset_counters", {overrun_count, timeout_err}, 0);
        reset = 1'b0; map_we = 1'b0;

        // overrun saturation while held in INIT
        frame_tick = 1'b1;
        tick(10);
        chk("overrun_9", overrun_count, 9);
        tick(250);
        frame_tick = 1'b0;
        chk("overrun_sat", overrun_count, 255);
        chk("still_init", init, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
